data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM-stage load/store port and a word-serial main-memory port. The cache does the following:
- Serves hits in the cycle the request is presented.
- Stalls the pipeline through `miss` while it writes back a dirty victim line and refills the target line.
- Stores per-byte writes through a 4-bit byte-enable mask in the same format as the core's `cache_write_en`.

## Interface
Parameters:
- `LINE_ADDR_LEN`, 2: log2(words per line). Default is 4 words per line.
- `SET_ADDR_LEN`, 4: log2(sets). Default is 16 sets. Tag width = 30 − `LINE_ADDR_LEN` − `SET_ADDR_LEN`.

Ports:
- Reset scheme: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_req` in 1: load request.
- `wr_en` in 4: store byte enables; any bit set means store request.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `wr_data` in 32: store data, byte-lane aligned.
- `rd_data` out 32: load word, combinational on hit.
- `miss` out 1: stall; core holds request stable while high.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: word-aligned beat address.
- `mem_wdata` out 32: write-beat data.
- `mem_gnt` in 1: beat accepted this cycle.
- `mem_rdata` in 32: read data, valid in the cycle `mem_gnt` is high.
- `hit_cnt` out 32: hit counter (see Configuration).
- `miss_cnt` out 32: miss counter (see Configuration).

## Operation
- Address split:
  - offset = `addr[LINE_ADDR_LEN+1:2]`
  - set = next `SET_ADDR_LEN` bits
  - tag = remaining upper bits
- Per-set storage: `valid`, `dirty`, tag, and line words.
- Request is active when `rd_req` is high or `wr_en` is nonzero. If both are present, the write wins; the read is not serviced separately.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - Hit (valid and tag match):
    - `miss`=0.
    - `rd_data` = stored word.
    - A store updates the enabled bytes and sets `dirty` at the clock edge.
  - Miss with victim valid and dirty: go to WRITEBACK.
  - Miss otherwise: go to FILL.
  - `miss`=1 combinationally in the cycle the miss is detected.
- WRITEBACK:
  - Control: `mem_req`=1, `mem_we`=1.
  - Addressing: `mem_addr` = {victim tag, set, beat counter, 2'b00}; `mem_wdata` = victim word[counter].
  - Counter advances on `mem_gnt`.
  - After the last beat (counter = 2^`LINE_ADDR_LEN`−1 with `mem_gnt`): clear `dirty`, reset counter, go to FILL.
- FILL:
  - Control: `mem_req`=1, `mem_we`=0.
  - Addressing: `mem_addr` = {request tag, set, counter, 2'b00}.
  - Data: on `mem_gnt`, `mem_rdata` is written into word[counter].
  - After the last beat: set tag, `valid`=1, `dirty`=0, go to IDLE.
- `miss` = 1 in WRITEBACK and FILL. On return to IDLE the held request hits and completes; stores set `dirty` at that point.
- `mem_req`=0 in IDLE. `mem_wdata`/`mem_addr` are don't-care when `mem_req`=0.
- Counter width is `LINE_ADDR_LEN`; it wraps to 0 naturally after the last beat.

## Timing
- Hit latency: 0 cycles; data is combinational and no stall occurs.
- Clean miss, zero-wait memory, 4-word line:
  - cycle N: detect, `miss`=1.
  - cycles N+1..N+4: FILL beats.
  - cycle N+5: IDLE hit, `miss`=0.
- Dirty miss adds 4 WRITEBACK beats, so `miss` falls at N+9.
- `mem_gnt` may stall any beat indefinitely. The beat is held, and `mem_addr`/`mem_wdata` stay stable until granted.
- Reset values:
  - FSM IDLE, counter 0.
  - All `valid` and `dirty` = 0; data and tags are not reset.
  - `mem_req`=0, `mem_we`=0, `miss`=0 with no request.
  - `hit_cnt`=0, `miss_cnt`=0.
- Reset asserted mid-WRITEBACK/FILL: abort immediately, `mem_req` drops asynchronously, and every line is invalid after release. Partially written-back data is lost; this is accepted.
- A request whose `addr` changes while `miss`=1 is a protocol violation; behaviour is undefined.

## Configuration
- Macro: `DCACHE_STATS_EN`.
- Defined:
  - `hit_cnt` increments once per request completing as a hit in IDLE without a preceding miss.
  - `miss_cnt` increments once per IDLE miss detection; the post-refill completion is not counted as a hit.
  - Both counters are 32-bit and wrap at 2^32.
- Undefined: counter logic is omitted, and `hit_cnt`/`miss_cnt` are tied to 0.

## Test plan
- Cold load, clean miss:
  - Stimulus: reset, `rd_req` at 0x100; memory returns 0x11, 0x22, 0x33, 0x44 at 0x100–0x10C with zero wait.
  - Response: `miss` high 5 cycles, then `rd_data`=0x11. A following load of 0x108 hits with 0x33 and `miss`=0.
- Byte store, then load:
  - Stimulus: `wr_en`=4'b0010, `wr_data`=0x0000AB00 at 0x104.
  - Response: load 0x104 returns 0x0000AB22, and the line is dirty.
- Dirty eviction:
  - Stimulus: load 0x200 (same set 0, different tag).
  - Response: 4 write beats to 0x100–0x10C with data 0x11, 0x0000AB22, 0x33, 0x44; then 4 read beats from 0x200; `miss` falls at N+9.
- Memory wait states:
  - Stimulus: `mem_gnt` low 3 cycles before each beat.
  - Response: `mem_addr` is held constant through the waits, and the stall extends by 12 cycles for a clean refill.
- Reset mid-FILL:
  - Stimulus: assert `rst`=0 after beat 2 of a refill.
  - Response: `mem_req`=0 immediately; after release, a load of the same address misses again.
- With `DCACHE_STATS_EN`:
  - Stimulus: scenarios 1–3 run in sequence.
  - Response: `miss_cnt`=2, `hit_cnt`=3.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the
// MEM-stage load/store port and a word-serial main-memory port.
//
// Hits are served combinationally in the cycle the request is presented. On a
// miss the cache raises `miss`, writes back a dirty victim line if there is
// one, refills the target line, and then completes the held request as a hit.
//
// Optional feature: define DCACHE_STATS_EN to build the hit/miss counters.
// Without it, hit_cnt and miss_cnt are tied to zero.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   rd_req     load request
//   wr_en      store byte enables (any bit set = store request)
//   addr       byte address, bits [1:0] ignored
//   wr_data    store data, byte-lane aligned
//   rd_data    load word, combinational on hit
//   miss       stall; the core holds its request stable while high
//   mem_req    memory beat request
//   mem_we     1 = write beat, 0 = read beat
//   mem_addr   word-aligned beat address
//   mem_wdata  write-beat data
//   mem_gnt    beat accepted this cycle
//   mem_rdata  read data, valid while mem_gnt is high
//   hit_cnt    completed-hit counter
//   miss_cnt   miss-detection counter
module data_cache #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [3:0]  wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;
  localparam int IDX_W   = SET_ADDR_LEN + LINE_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t                   state;
  logic [LINE_ADDR_LEN-1:0] cnt;
  logic [SETS-1:0]          valid;
  logic [SETS-1:0]          dirty;
  logic [TAG_LEN-1:0]       tags     [SETS];
  logic [31:0]              data_mem [SETS*WORDS];

  logic [LINE_ADDR_LEN-1:0] off;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_LEN-1:0]       tag;
  logic                     addr_unused;
  logic                     req;
  logic                     is_wr;
  logic                     hit;
  logic                     last_beat;
  logic [IDX_W-1:0]         req_idx;
  logic [IDX_W-1:0]         beat_idx;

  assign off         = addr[LINE_ADDR_LEN+1:2];
  assign set_idx     = addr[IDX_W+1:LINE_ADDR_LEN+2];
  assign tag         = addr[31:IDX_W+2];
  // The two byte-offset bits play no part in word addressing.
  assign addr_unused = ^addr[1:0];

  assign is_wr     = |wr_en;
  assign req       = rd_req | is_wr;
  assign hit       = valid[set_idx] && (tags[set_idx] == tag);
  assign last_beat = &cnt;
  assign req_idx   = {set_idx, off};
  assign beat_idx  = {set_idx, cnt};

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops mem_req immediately.
  assign rd_data   = data_mem[req_idx];
  assign miss      = (state != IDLE) || (req && !hit);
  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == WRITEBACK);
  assign mem_wdata = data_mem[beat_idx];

  always_comb begin
    mem_addr = {tag, set_idx, cnt, 2'b00};
    if (state == WRITEBACK) begin
      // Write-back targets the victim line, whose tag is still stored.
      mem_addr = {tags[set_idx], set_idx, cnt, 2'b00};
    end
  end

  // Control: FSM, beat counter, valid/dirty bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (is_wr) dirty[set_idx] <= 1'b1;
            end else if (valid[set_idx] && dirty[set_idx]) begin
              state <= WRITEBACK;
            end else begin
              state <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_gnt) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              dirty[set_idx] <= 1'b0;
              state          <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_gnt) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              valid[set_idx] <= 1'b1;
              dirty[set_idx] <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en[b]) data_mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (state == FILL && mem_gnt) begin
      data_mem[beat_idx] <= mem_rdata;
      if (last_beat) tags[set_idx] <= tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // refilled marks that the next IDLE hit is the completion of a refilled
  // request, which is already counted as a miss.
  logic refilled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      refilled <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        if (hit) begin
          if (refilled) refilled <= 1'b0;
          else          hit_cnt  <= hit_cnt + 32'd1;
        end else begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
      if (state == FILL && mem_gnt && last_beat) refilled <= 1'b1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [3:0]  wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

`ifdef DCACHE_STATS_EN
  localparam logic [31:0] EXP_HIT  = 32'd3;
  localparam logic [31:0] EXP_MISS = 32'd2;
`else
  localparam logic [31:0] EXP_HIT  = 32'd0;
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  // kind: 0 = load completion, 1 = write beat, 2 = read beat
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wait_n = 0;
  int          wait_cnt = 0;
  int          beats_seen = 0;
  logic [31:0] held_addr = '0;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic push_fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      sb_q.push_back('{kind: 2, a: base + 4*i, d: mem_rd(base + 4*i)});
  endtask

  // Memory responder: decides grant on the falling edge, consumes beats on
  // the rising edge and checks them against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_req === 1'b1) begin
      if (wait_cnt < wait_n) begin
        if (wait_cnt == 0) held_addr = mem_addr;
        mem_gnt = 1'b0;
        wait_cnt++;
      end else begin
        if (wait_n > 0) chk("addr_hold", mem_addr, held_addr);
        mem_gnt   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
      end
    end else begin
      mem_gnt  = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
      sb_t e;
      beats_seen++;
      wait_cnt = 0;
      chk("beat_expected", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("beat_kind", mem_we ? 32'd1 : 32'd2, e.kind);
        chk("beat_addr", mem_addr, e.a);
        if (mem_we) chk("beat_wdata", mem_wdata, e.d);
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Present one request, count stall cycles, check the completed load.
  task automatic access(input logic r, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_stall, input string tag);
    int   stall;
    sb_t  e;
    @(posedge clk); #1;
    rd_req = r; wr_en = be; addr = a; wr_data = wd;
    stall = 0;
    forever begin
      @(negedge clk);
      if (miss !== 1'b1) break;
      stall++;
      if (stall > 300) break;
    end
    chk({tag, "_stall"}, stall, exp_stall);
    if (be == 4'b0000) begin
      chk({tag, "_sb_load"}, sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_kind"}, 32'd0, e.kind);
        chk({tag, "_rd_data"}, rd_data, e.d);
      end
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_en = 4'b0000;
  endtask

  initial begin
    int b0;
    int guard;
    rst = 1'b0; rd_req = 1'b0; wr_en = '0; addr = '0; wr_data = '0;
    mem_gnt = 1'b0; mem_rdata = '0;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      mem[32'h200 + 4*i] = 32'hA000_0000 + i;
      mem[32'h2C0 + 4*i] = 32'hC000_0000 + i;
      mem[32'h340 + 4*i] = 32'h3400_0000 + i;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_miss", miss, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Cold load, clean miss, then a hit in the same line.
    push_fill(32'h100, 4);
    sb_q.push_back('{kind: 0, a: 32'h100, d: 32'h11});
    access(1'b1, 4'b0000, 32'h100, '0, 5, "cold");
    sb_q.push_back('{kind: 0, a: 32'h108, d: 32'h33});
    access(1'b1, 4'b0000, 32'h108, '0, 0, "hit108");

    // Byte store to lane 1, then read back.
    access(1'b0, 4'b0010, 32'h104, 32'h0000_AB00, 0, "store");
    sb_q.push_back('{kind: 0, a: 32'h104, d: 32'h0000_AB22});
    access(1'b1, 4'b0000, 32'h104, '0, 0, "ld104");

    // Dirty eviction of set 0.
    sb_q.push_back('{kind: 1, a: 32'h100, d: 32'h11});
    sb_q.push_back('{kind: 1, a: 32'h104, d: 32'h0000_AB22});
    sb_q.push_back('{kind: 1, a: 32'h108, d: 32'h33});
    sb_q.push_back('{kind: 1, a: 32'h10C, d: 32'h44});
    push_fill(32'h200, 4);
    sb_q.push_back('{kind: 0, a: 32'h200, d: 32'hA000_0000});
    access(1'b1, 4'b0000, 32'h200, '0, 9, "evict");
    chk("hit_cnt", hit_cnt, EXP_HIT);
    chk("miss_cnt", miss_cnt, EXP_MISS);

    // Clean refill with three wait cycles before every beat.
    wait_n = 3;
    push_fill(32'h2C0, 4);
    sb_q.push_back('{kind: 0, a: 32'h2C8, d: 32'hC000_0002});
    access(1'b1, 4'b0000, 32'h2C8, '0, 17, "waits");
    wait_n = 0;

    // Reset after the second fill beat.
    push_fill(32'h340, 2);
    b0 = beats_seen;
    @(posedge clk); #1;
    rd_req = 1'b1; addr = 32'h340;
    guard = 0;
    while (beats_seen < b0 + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_fill_beats", beats_seen - b0, 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_hit_cnt", hit_cnt, 32'd0);
    chk("abort_miss_cnt", miss_cnt, 32'd0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    push_fill(32'h340, 4);
    sb_q.push_back('{kind: 0, a: 32'h340, d: 32'h3400_0000});
    access(1'b1, 4'b0000, 32'h340, '0, 5, "refetch");
    push_fill(32'h200, 4);
    sb_q.push_back('{kind: 0, a: 32'h204, d: 32'hA000_0001});
    access(1'b1, 4'b0000, 32'h204, '0, 5, "inval200");
    sb_q.push_back('{kind: 0, a: 32'h34C, d: 32'h3400_0003});
    access(1'b1, 4'b0000, 32'h34C, '0, 0, "hit34c");

    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
